div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative multi-cycle divider for the RV32M ops DIV, DIVU, REM and REMU, built as a sibling of the ALU compare/arithmetic modules.
- Takes two operands and an op select through a valid/ready request channel.
- Runs a restoring shift-subtract loop, one bit per cycle; each step is a compare-and-subtract, the same sign/borrow logic as set-less-than.
- Returns the result through a valid/ready response channel to the execute stage.

Parameters:
WIDTH, 32, operand/result width in bits; the loop counter is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request; high only in IDLE.
op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
X  input  WIDTH  dividend.
Y  input  WIDTH  divisor.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset state (asserted asynchronously): state=IDLE, in_ready=1, out_valid=0, result=0; all internal registers 0.
- Accept rule: a request is accepted on a rising edge where in_valid && in_ready. X, Y and op are captured on that edge and never sampled again.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On accept with Y==0, go to DONE.
  - On accept with signed overflow (op DIV/REM, X==0x80000000, Y==0xFFFFFFFF), go to DONE.
  - On any other accept, go to CALC with count=WIDTH.
- Operand setup (signed ops): take magnitudes |X| and |Y|. Record neg_q = X[MSB]^Y[MSB] and neg_r = X[MSB]. Unsigned ops use X and Y as-is.
- CALC, one step per cycle:
  - rem = {rem[WIDTH-2:0], dvd[MSB]}; shift dvd left by 1.
  - If rem >= div, subtract div and shift a 1 into the quotient; otherwise shift in a 0.
  - Decrement count; go to FIX when count reaches 1 at the end of a cycle. CALC lasts exactly WIDTH cycles.
- FIX (1 cycle): select quotient or remainder per op. Negate the quotient if neg_q and the remainder if neg_r (signed ops only). Load result, go to DONE.
- DONE: out_valid=1 and result held stable. Return to IDLE on the edge where out_ready=1.
- Latency, counted from the accept edge to out_valid rising:
  - Normal: WIDTH+2 cycles, i.e. 34 at WIDTH=32.
  - Special cases: 1 cycle.
  - Back-to-back requests: the next accept can happen no earlier than the cycle after the handshake.
- Special-case results:
  - Y==0: DIV/DIVU give all-ones; REM/REMU give X.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- Backpressure: out_valid stays high and result is frozen for any number of cycles with out_ready=0. in_ready stays 0 throughout.
- Ignored inputs: in_valid is ignored outside IDLE; X, Y and op changes after accept have no effect.
- Reset mid-operation aborts immediately. There is no partial output, and the first post-reset request behaves normally.
- Width rules: all arithmetic is WIDTH bits. The rem>=div comparison is unsigned, at WIDTH+1 bits via borrow. Negation is two's complement modulo 2^WIDTH.

Decomposition:
- Shared alu_pkg holds:
  - the op encoding constants DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11;
  - the FSM state encoding;
  - the constant INT_MIN = {1'b1, {WIDTH-1{1'b0}}}.
- One sub-module, div_step: a combinational single iteration.
  - Inputs: rem, div, dvd_msb.
  - Outputs: next_rem, q_bit.
  - Instantiated once in the FSM datapath.

Test Plan:
- DIV X=20, Y=3, out_ready=1 -> out_valid rises 34 cycles after accept, result=6; REM with the same operands -> 2.
- DIV X=-20 (0xFFFFFFEC), Y=3 -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1.
- Special cases, each with out_valid one cycle after accept:
  - DIVU X=7, Y=0 -> 0xFFFFFFFF; REM X=7, Y=0 -> 7.
  - DIV X=0x80000000, Y=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, while changing X/Y and pulsing in_valid -> result stays stable, in_ready=0. With out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 mid-CALC (cycle 10) -> outputs immediately take reset values. Then issue DIVU 100/7 -> result 14 after 34 cycles.
- Back-to-back requests with in_valid held high and out_ready=1 -> exactly one accept per result, and each result matches its own request's operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sibling units: op encodings, divider FSM states, constants.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    // M-extension divide/remainder op encodings; bit 1 selects remainder, bit 0 selects unsigned.
    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Signed ops are DIV and REM.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Selects the remainder rather than the quotient.
    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare against the divisor, subtract.
module div_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] div,
    input  logic             dvd_msb,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0] shifted;
    logic [SW:0]   diff;

    // Compare at WIDTH+1 bits so a shifted-out remainder MSB is never lost; the borrow is the compare.
    always_comb begin
        shifted  = {rem, dvd_msb};
        diff     = {1'b0, shifted} - {2'b00, div};
        q_bit    = ~diff[SW];
        next_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle, valid/ready on both sides.
module div_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] dvd, dvd_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] div_r, div_n;
    logic [1:0]       op_r, op_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic [WIDTH-1:0] result_n;
    logic             in_ready_n;
    logic             out_valid_n;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .div      (div_r),
        .dvd_msb  (dvd[WIDTH-1]),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    // State register and registered datapath/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            rem       <= '0;
            dvd       <= '0;
            quo       <= '0;
            div_r     <= '0;
            op_r      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            rem       <= rem_n;
            dvd       <= dvd_n;
            quo       <= quo_n;
            div_r     <= div_n;
            op_r      <= op_n;
            neg_q     <= neg_q_n;
            neg_r     <= neg_r_n;
            result    <= result_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
        end
    end

    // Next-state and datapath: capture/special-case on accept, iterate, sign-fix, hold until taken.
    always_comb begin
        state_n  = state;
        count_n  = count;
        rem_n    = rem;
        dvd_n    = dvd;
        quo_n    = quo;
        div_n    = div_r;
        op_n     = op_r;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result;

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_n    = op;
                    rem_n   = '0;
                    quo_n   = '0;
                    neg_q_n = 1'b0;
                    neg_r_n = 1'b0;
                    if (Y == '0) begin
                        state_n  = S_DONE;
                        result_n = is_rem_op(op) ? X : '1;
                    end else if (is_signed_op(op) && (X == MIN_NEG) && (Y == '1)) begin
                        state_n  = S_DONE;
                        result_n = is_rem_op(op) ? '0 : MIN_NEG;
                    end else begin
                        state_n = S_CALC;
                        count_n = CW'(WIDTH);
                        if (is_signed_op(op)) begin
                            dvd_n   = X[WIDTH-1] ? WIDTH'(-X) : X;
                            div_n   = Y[WIDTH-1] ? WIDTH'(-Y) : Y;
                            neg_q_n = X[WIDTH-1] ^ Y[WIDTH-1];
                            neg_r_n = X[WIDTH-1];
                        end else begin
                            dvd_n = X;
                            div_n = Y;
                        end
                    end
                end
            end
            S_CALC: begin
                rem_n   = step_rem;
                quo_n   = {quo[WIDTH-2:0], step_q};
                dvd_n   = {dvd[WIDTH-2:0], 1'b0};
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    state_n = S_FIX;
                end
            end
            S_FIX: begin
                if (is_rem_op(op_r)) begin
                    result_n = (is_signed_op(op_r) && neg_r) ? WIDTH'(-rem) : rem;
                end else begin
                    result_n = (is_signed_op(op_r) && neg_q) ? WIDTH'(-quo) : quo;
                end
                state_n = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, latency, backpressure, reset, back-to-back.
module tb_div_unit;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] X;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_assert;
    int n_fail;
    int acc_cnt;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept counter for the back-to-back check.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid, sampling on negedges; returns cycles since the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    // Issue one request from a negedge, scramble inputs after accept, check latency/result and handshake.
    task automatic run_req(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        op = o; X = x; Y = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X = $urandom; Y = $urandom; op = 2'($urandom);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        b2b [3];
        logic [31:0] held;
        int          lat;
        int          acc_start;

        n_assert  = 0;
        n_fail    = 0;
        acc_cnt   = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = 2'b00; X = '0; Y = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic signed/unsigned arithmetic.
        run_req("div_20_3",   DIV_OP,  32'd20,         32'd3,          32'd6,          34);
        run_req("rem_20_3",   REM_OP,  32'd20,         32'd3,          32'd2,          34);
        run_req("div_m20_3",  DIV_OP,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFA,  34);
        run_req("rem_m20_3",  REM_OP,  32'hFFFF_FFEC,  32'd3,          32'hFFFF_FFFE,  34);
        run_req("div_20_m3",  DIV_OP,  32'd20,         32'hFFFF_FFFD,  32'hFFFF_FFFA,  34);
        run_req("rem_20_m3",  REM_OP,  32'd20,         32'hFFFF_FFFD,  32'd2,          34);
        run_req("divu_max_2", DIVU_OP, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  34);
        run_req("remu_max_2", REMU_OP, 32'hFFFF_FFFF,  32'd2,          32'd1,          34);
        run_req("divu_big",   DIVU_OP, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          34);
        run_req("remu_big",   REMU_OP, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34);

        // Special cases: one-cycle turnaround.
        run_req("divu_by0",   DIVU_OP, 32'd7,          32'd0,          32'hFFFF_FFFF,  1);
        run_req("rem_by0",    REM_OP,  32'd7,          32'd0,          32'd7,          1);
        run_req("div_ovf",    DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_req("rem_ovf",    REM_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

        // Backpressure: result frozen, inputs ignored while out_ready is low.
        out_ready = 1'b0;
        run_req("bp_divu", DIVU_OP, 32'd1000, 32'd10, 32'd100, 34);
        held = result;
        for (int i = 0; i < 10; i++) begin
            X = $urandom; Y = $urandom; op = 2'($urandom);
            in_valid = (i % 2) == 0;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'd100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_held_result", result, held);

        // Reset in the middle of an iteration.
        op = DIVU_OP; X = 32'h0000_FFFF; Y = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req("post_rst_divu", DIVU_OP, 32'd100, 32'd7, 32'd14, 34);

        // Back-to-back with in_valid held high.
        b2b[0] = '{DIVU_OP, 32'd1000,        32'd10,        32'd100};
        b2b[1] = '{REM_OP,  32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF};
        b2b[2] = '{DIV_OP,  32'd100,         32'hFFFF_FFF9, 32'hFFFF_FFF2};
        acc_start = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            check("b2b_in_ready_pre", 32'(in_ready), 32'd1);
            op = b2b[k].o; X = b2b[k].x; Y = b2b[k].y; in_valid = 1'b1;
            wait_valid(lat);
            check("b2b_latency", 32'(lat), 32'd34);
            check("b2b_result", result, b2b[k].exp);
            check("b2b_accepts", 32'(acc_cnt - acc_start), 32'(k + 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_total_accepts", 32'(acc_cnt - acc_start), 32'd3);
        check("b2b_final_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
